// File: rtl/uart_rx.sv
// Serial receiver for start/WORD_BITS data/stop frames that writes each good word into a downstream fifo.
// The write strobe comes about 2 + CLKS_PER_BIT/2 + (WORD_BITS+1)*CLKS_PER_BIT clocks after the start edge; full_i drops the word as overrun_o and never stalls the line.
module uart_rx #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int WORD_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rx_i,
  input  logic                 full_i,
  output logic                 write_o,
  output logic [WORD_BITS-1:0] wdata_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = $clog2(WORD_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], rx_i};
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // A start bit that is already high again at its midpoint is treated as a glitch.
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[WORD_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == WORD_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          if (!rx_s) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else if (full_i) begin
            overrun_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            write_d = 1'b1;
            wdata_d = shift_q;
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end

      S_BREAK: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign write_o     = write_q;
  assign wdata_o     = wdata_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

  a_pulse_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0({write_q, frame_err_q, overrun_q}));

  a_pulse_single: assert property (@(posedge clk_i) disable iff (reset_i)
    (write_q || frame_err_q || overrun_q) |=> !(write_q || frame_err_q || overrun_q));

endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame bench for uart_rx with a frame-outcome reference model and pulse monitor.
module tb_uart_rx;
  localparam int CPB = 10;

  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i    = 1'b1;
  logic       full_i  = 1'b0;
  logic       write_o;
  logic [7:0] wdata_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Observed pulse history
  int         n_wr = 0, n_fe = 0, n_ov = 0;
  int         last_wr_cyc = 0;
  logic [7:0] got_q[$];
  logic       prev_pulse = 1'b0;

  // Reference model state
  int         exp_wr = 0, exp_fe = 0, exp_ov = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_wdata = 8'h00;
  int         frame_start = 0;

  uart_rx #(
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .WORD_BITS(8)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rx_i       (rx_i),
    .full_i     (full_i),
    .write_o    (write_o),
    .wdata_o    (wdata_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_pulse = 1'b0;
    end else begin
      if (write_o || frame_err_o || overrun_o) begin
        check("pulse_excl", 32'(write_o) + 32'(frame_err_o) + 32'(overrun_o), 1);
        check("pulse_gap", 32'(prev_pulse), 0);
        if (write_o) begin
          n_wr++;
          got_q.push_back(wdata_o);
          last_wr_cyc = cyc;
        end
        if (frame_err_o) n_fe++;
        if (overrun_o) n_ov++;
      end
      prev_pulse = write_o || frame_err_o || overrun_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_i = 1'b0;
    frame_start = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(CPB);
    end
    rx_i = stop_bit;
    tick(CPB);
  endtask

  // Model: a good stop bit writes the word unless full, a low stop bit is a framing error.
  task automatic do_frame(input logic [7:0] d, input logic stop_bit, input logic full, input int gap);
    full_i = full;
    send_frame(d, stop_bit);
    if (!stop_bit) begin
      exp_fe++;
    end else if (full) begin
      exp_ov++;
    end else begin
      exp_wr++;
      exp_q.push_back(d);
      exp_wdata = d;
    end
    check("write_count", n_wr, exp_wr);
    check("ferr_count", n_fe, exp_fe);
    check("ovr_count", n_ov, exp_ov);
    check("wdata", 32'(wdata_o), 32'(exp_wdata));
    rx_i = 1'b1;
    tick(gap);
  endtask

  initial begin
    int lat;
    logic [7:0] d;
    logic       stop_bit;
    logic       full;
    int         gap;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_write", 32'(write_o), 0);
    check("rst_ferr", 32'(frame_err_o), 0);
    check("rst_ovr", 32'(overrun_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_wdata", 32'(wdata_o), 0);
    reset_i = 1'b0;
    tick(20);

    do_frame(8'hA5, 1'b1, 1'b0, 10);
    lat = last_wr_cyc - frame_start;
    check("latency_window", 32'((lat >= 95) && (lat <= 99)), 1);
    check("busy_after_a5", 32'(busy_o), 0);

    do_frame(8'h00, 1'b1, 1'b0, 0);
    do_frame(8'hFF, 1'b1, 1'b0, 10);

    do_frame(8'h5A, 1'b1, 1'b1, 10);
    full_i = 1'b0;

    full_i = 1'b0;
    send_frame(8'h3C, 1'b0);
    exp_fe++;
    tick(30);
    check("brk_ferr_count", n_fe, exp_fe);
    check("brk_write_count", n_wr, exp_wr);
    check("brk_busy_low_line", 32'(busy_o), 1);
    rx_i = 1'b1;
    tick(6);
    check("brk_exit_busy", 32'(busy_o), 0);
    do_frame(8'h3C, 1'b1, 1'b0, 10);

    rx_i = 1'b0;
    tick(3);
    check("glitch_busy_rise", 32'(busy_o), 1);
    rx_i = 1'b1;
    tick(7);
    check("glitch_busy_fall", 32'(busy_o), 0);
    check("glitch_write", n_wr, exp_wr);
    check("glitch_ferr", n_fe, exp_fe);
    check("glitch_ovr", n_ov, exp_ov);
    tick(10);

    d = 8'h96;
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_i = d[i];
      tick(CPB);
    end
    rx_i = d[4];
    tick(5);
    check("midframe_busy", 32'(busy_o), 1);
    reset_i = 1'b1;
    #1;
    check("arst_write", 32'(write_o), 0);
    check("arst_ferr", 32'(frame_err_o), 0);
    check("arst_ovr", 32'(overrun_o), 0);
    check("arst_busy", 32'(busy_o), 0);
    check("arst_wdata", 32'(wdata_o), 0);
    rx_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    exp_wdata = 8'h00;
    tick(20);
    check("post_rst_write", n_wr, exp_wr);
    do_frame(8'hC3, 1'b1, 1'b0, 10);

    for (int k = 0; k < 20; k++) begin
      d        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 7) != 0);
      full     = ($urandom_range(0, 3) == 0);
      gap      = stop_bit ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 15));
      do_frame(d, stop_bit, full, gap);
    end
    full_i = 1'b0;
    tick(30);

    check("total_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("word_seq", 32'(got_q[i]), 32'(exp_q[i]));
    end
    check("final_busy", 32'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate.
REQ-003 Parameter WORD_BITS, default 8, data bits per frame; matches the downstream fifo WORD_BITS.
REQ-004 Local constant CLKS_PER_BIT SHALL equal CLK_HZ/BAUD (integer truncation); configurations giving CLKS_PER_BIT < 4 are unsupported.
REQ-005 clk_i  input  1  single system clock, all logic on rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 rx_i  input  1  asynchronous serial line, idle high; 8N1-style frame: start 0, WORD_BITS data LSB first, one stop 1.
REQ-008 full_i  input  1  downstream fifo full flag.
REQ-009 write_o  output  1  one-cycle write strobe to the fifo write port.
REQ-010 wdata_o  output  WORD_BITS  received word, valid while write_o is high.
REQ-011 frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 overrun_o  output  1  one-cycle pulse: valid word dropped because full_i was high.
REQ-013 busy_o  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 rx_i SHALL pass through a 2-flop synchronizer (both flops reset to 1); all FSM decisions use the synchronized value rx_s.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, STOP, and BREAK.
REQ-016 IDLE: bit counter and clock counter held at 0; on rx_s==0 -> START.
REQ-017 START: count CLKS_PER_BIT/2 clocks (mid start bit); if rx_s==0 -> DATA with clock counter cleared; if rx_s==1 -> IDLE (glitch rejected, no output activity).
REQ-018 DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register, LSB first; after WORD_BITS samples -> STOP.
REQ-019 STOP: after CLKS_PER_BIT clocks, sample rx_s.
REQ-020 STOP sample 1 with full_i==0: write_o=1 for exactly one cycle, wdata_o=assembled word, -> IDLE.
REQ-021 STOP sample 1 with full_i==1 (sampled in the same cycle): no write; overrun_o=1 for one cycle; wdata_o unchanged; -> IDLE.
REQ-022 STOP sample 0: no write; frame_err_o=1 for one cycle; -> BREAK.
REQ-023 BREAK: remain until rx_s==1, then -> IDLE; a low line never starts a new frame from BREAK.
REQ-024 write_o, frame_err_o, and overrun_o SHALL be registered and mutually exclusive, and none SHALL assert for two consecutive cycles.
REQ-025 wdata_o SHALL hold its last written value until the next write_o.
REQ-026 Return to IDLE at mid stop bit allows back-to-back frames with no idle gap.
REQ-027 Nominal latency from the rx_i falling edge to write_o SHALL be 2 + CLKS_PER_BIT/2 + (WORD_BITS+1)*CLKS_PER_BIT clocks, within +/-2 clocks.
REQ-028 Counters SHALL be sized ceil(log2(CLKS_PER_BIT)) and ceil(log2(WORD_BITS+1)) bits, and SHALL never wrap within a state.

Reset
REQ-029 Asserting reset_i SHALL immediately force: state IDLE, counters 0, shift register 0, wdata_o 0, write_o 0, frame_err_o 0, overrun_o 0, busy_o 0, and synchronizer flops 1.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first full frame after reset release is received correctly.

Verification (CLK_HZ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10, WORD_BITS=8)
REQ-031 Frame 0xA5, full_i=0 -> exactly one write_o pulse with wdata_o=0xA5, about 97 clocks after the start edge; no error pulses; busy_o returns to 0.
REQ-032 Frames 0x00 then 0xFF sent back-to-back without an idle gap -> two write_o pulses, with wdata_o 0x00 then 0xFF.
REQ-033 Frame 0x5A with full_i=1 -> no write_o, one overrun_o pulse, wdata_o keeps its previous value.
REQ-034 Frame 0x3C with the stop bit driven 0, line held low 30 clocks, then high -> one frame_err_o pulse, no write_o, FSM in BREAK until the line goes high; a following 0x3C frame is received correctly.
REQ-035 rx_i low glitch of 3 clocks -> busy_o rises then falls within 10 clocks; no write_o, frame_err_o, or overrun_o.
REQ-036 reset_i pulsed during data bit 4 of a frame -> all outputs 0 within the reset cycle; the next 0xC3 frame yields write_o with wdata_o=0xC3.
